// File: rtl/prbs_launch_if.sv
// prbs_launch_if: launch-enable input and data/sync outputs of the PRBS7 launcher.
// With PRBS_ERRINJ_EN defined the bundle also carries the err injection input.
interface prbs_launch_if;
  logic en;
`ifdef PRBS_ERRINJ_EN
  logic err;
`endif
  logic q;
  logic qb;
  logic sync;

`ifdef PRBS_ERRINJ_EN
  modport master (output en, output err, input q, input qb, input sync);
  modport slave  (input en, input err, output q, output qb, output sync);
`else
  modport master (output en, input q, input qb, input sync);
  modport slave  (input en, output q, output qb, output sync);
`endif
endinterface

// File: rtl/prbs_launch.sv
// prbs_launch: PRBS7 (x^7 + x^6 + 1) data launcher driving a complementary pair plus a
// frame-sync marker that is high for the bit at sequence index 0.
// Digital abstraction of the launcher: voltage levels map to 1/0, and the clock-to-q
// delay and transition time collapse onto the launching edge.
// Dir selects the active edge (+1 rising, -1 falling). Seed must be non-zero.
// Optional feature: define PRBS_ERRINJ_EN to add bus.err, which inverts the launched bit
// on q/qb only; the LFSR, index and sync are not disturbed.
module prbs_launch #(
  parameter int         Dir  = 1,
  parameter logic [6:0] Seed = 7'd127
) (
  input logic          clk,
  input logic          rst,
  prbs_launch_if.slave bus
);

  logic [6:0] s_q, s_d;  // LFSR state, s_q[6] is the next bit out
  logic [6:0] n_q, n_d;  // sequence index of the next launch, 0..126
  logic       b_q, b_d;  // launched bit
  logic       f_q, f_d;  // sync flag for the launched bit
  logic       launch_bit;

  // Next state: advance only on enabled edges, otherwise every output holds.
  always_comb begin
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    f_d        = f_q;
    launch_bit = s_q[6];
`ifdef PRBS_ERRINJ_EN
    launch_bit = s_q[6] ^ bus.err;
`endif
    if (bus.en) begin
      b_d = launch_bit;
      f_d = (n_q == 7'd0);
      s_d = {s_q[5:0], s_q[6] ^ s_q[5]};
      n_d = (n_q == 7'd126) ? 7'd0 : n_q + 7'd1;
    end
  end

  generate
    if (Dir < 0) begin : g_fall
      // State register on the falling clock edge; reset is a level and wins over the edge.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          s_q <= Seed;
          n_q <= 7'd0;
          b_q <= 1'b0;
          f_q <= 1'b0;
        end else begin
          s_q <= s_d;
          n_q <= n_d;
          b_q <= b_d;
          f_q <= f_d;
        end
      end
    end else begin : g_rise
      // State register on the rising clock edge; reset is a level and wins over the edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= Seed;
          n_q <= 7'd0;
          b_q <= 1'b0;
          f_q <= 1'b0;
        end else begin
          s_q <= s_d;
          n_q <= n_d;
          b_q <= b_d;
          f_q <= f_d;
        end
      end
    end
  endgenerate

  assign bus.q    = b_q;
  assign bus.qb   = ~b_q;
  assign bus.sync = f_q;

endmodule
